// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit that owns the HI/LO register pair.
// MULT/MULTU/DIV/DIVU take one bit per cycle; MTHI/MTLO complete in a single cycle.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    localparam logic [2:0]       OP_MTHI = 3'd4;
    localparam logic [2:0]       OP_MTLO = 3'd5;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] work_hi, work_lo, oper;
    logic             is_div, neg_res, neg_rem, div_zero;

    logic             signed_op;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    // op[2]=0 selects an arithmetic op; op[0]=0 means signed, op[1]=1 means divide.
    assign signed_op = ~op[0];
    assign mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;
    assign busy      = (state != IDLE);

    // Shift-add: work_lo holds the multiplier and collects the low product bits.
    assign mul_sum  = {1'b0, work_hi} + (work_lo[0] ? {1'b0, oper} : '0);

    // Restoring divide: partial remainder in work_hi, quotient shifts into work_lo.
    assign div_sh   = {work_hi, work_lo[WIDTH-1]};
    assign div_ge   = (div_sh >= {1'b0, oper});
    assign div_diff = div_sh[WIDTH-1:0] - oper;

    assign prod_fix = neg_res ? -{work_hi, work_lo} : {work_hi, work_lo};
    assign quo_fix  = div_zero ? '1 : (neg_res ? -work_lo : work_lo);
    assign rem_fix  = neg_rem ? -work_hi : work_hi;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        next_state = state;
        case (state)
            IDLE: if (start && !cancel && !op[2]) next_state = RUN;
            RUN: begin
                if (cancel)           next_state = IDLE;
                else if (cnt == LAST) next_state = FIX;
            end
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            work_hi  <= '0;
            work_lo  <= '0;
            oper     <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        if (!op[2]) begin
                            cnt      <= '0;
                            work_hi  <= '0;
                            work_lo  <= op[1] ? mag_a : mag_b;
                            oper     <= op[1] ? mag_b : mag_a;
                            is_div   <= op[1];
                            neg_res  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem  <= signed_op & a[WIDTH-1];
                            div_zero <= (b == '0);
                        end else if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                RUN: begin
                    if (!cancel) begin
                        cnt <= cnt + CNT_W'(1);
                        if (is_div) begin
                            work_hi <= div_ge ? div_diff : div_sh[WIDTH-1:0];
                            work_lo <= {work_lo[WIDTH-2:0], div_ge};
                        end else begin
                            work_hi <= mul_sum[WIDTH:1];
                            work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
                        end
                    end
                end
                FIX: begin
                    if (!cancel) begin
                        if (is_div) begin
                            lo <= quo_fix;
                            hi <= rem_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: latency, signed/unsigned results,
// divide-by-zero, overflow, MTHI/MTLO, cancel and asynchronous reset.
module tb_mul_div_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             cancel;
    logic             busy, done;
    logic [WIDTH-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one arithmetic op and check latency, done pulse and result.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int n;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, n, 33);
        check({tag, "_done"}, done, 1);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        reset = 1'b1;

        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg",  3'd0, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", 3'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
        run_op("div_zero_s",3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("multu_mix", 3'd1, 32'h0001_0000, 32'h0003_0005, 32'h0000_0003, 32'h0005_0000);

        // MTHI then MTLO on consecutive edges
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'h1234_5678;
        @(negedge clk);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_busy", busy, 0);
        op = 3'd5; a = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", lo, 32'h9ABC_DEF0);
        check("mtlo_hi_kept", hi, 32'h1234_5678);
        check("mtlo_busy", busy, 0);
        check("mtlo_done", done, 0);

        // DIVU 50/7 cancelled on the 10th busy cycle, with a stray start mid-RUN
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd50; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (i == 3) begin
                start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("cancel_busy_before", busy, 1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy_after", busy, 0);
        check("cancel_done", done, 0);
        check("cancel_hi", hi, 32'h1234_5678);
        check("cancel_lo", lo, 32'h9ABC_DEF0);
        @(negedge clk);
        check("cancel_done_late", done, 0);

        // cancel and start together in IDLE: nothing accepted
        cancel = 1'b1; start = 1'b1; op = 3'd3; a = 32'd50; b = 32'd7;
        @(negedge clk);
        check("cs_div_busy", busy, 0);
        op = 3'd4; a = 32'h1111_1111;
        @(negedge clk);
        op = 3'd5;
        @(negedge clk);
        cancel = 1'b0; start = 1'b0;
        check("cs_mthi_hi", hi, 32'h1234_5678);
        check("cs_mtlo_lo", lo, 32'h9ABC_DEF0);
        check("cs_busy", busy, 0);

        // Asynchronous reset in the middle of a MULTU
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("arst_busy_before", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        run_op("divu_after_rst", 3'd3, 32'd50, 32'd7, 32'd1, 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
